// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side handshake bundle between the FIFO read controller and its consumer.
interface fifo_rd_ptr_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              RD_EN_i;
    logic [ADDR_W:0]   WPTR_GRAY_i;
    logic [ADDR_W:0]   RPTR_GRAY_o;
    logic [ADDR_W-1:0] RADDR_o;
    logic              EMPTY_o;
    logic              RD_ACK_o;
    logic [ADDR_W:0]   LEVEL_o;
    logic              ALMOST_EMPTY_o;

    modport master (
        output RD_EN_i,
        output WPTR_GRAY_i,
        input  RPTR_GRAY_o,
        input  RADDR_o,
        input  EMPTY_o,
        input  RD_ACK_o,
        input  LEVEL_o,
        input  ALMOST_EMPTY_o
    );

    modport slave (
        input  RD_EN_i,
        input  WPTR_GRAY_i,
        output RPTR_GRAY_o,
        output RADDR_o,
        output EMPTY_o,
        output RD_ACK_o,
        output LEVEL_o,
        output ALMOST_EMPTY_o
    );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// Async FIFO read-domain pointer and empty-flag controller.
// Define RPTR_LEVEL_EN to build the fill level and almost-empty flag.
module fifo_rd_ptr_ctrl #(
    parameter int          ADDR_W    = 4,
    parameter int unsigned AE_THRESH = 2
) (
    input logic               CLK_i,
    input logic               RST_i,
    fifo_rd_ptr_ctrl_if.slave bus
);
    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wq1_q;
    logic [PW-1:0] wq1_d;
    logic [PW-1:0] wq2_q;
    logic [PW-1:0] wq2_d;
    logic [PW-1:0] rbin_q;
    logic [PW-1:0] rbin_d;
    logic [PW-1:0] rgray_q;
    logic [PW-1:0] rgray_d;
    logic          empty_q;
    logic          empty_d;
    logic          ack_q;
    logic          ack_d;
    logic          rd_acc;

    // Empty is judged against the next pointer so the last read
    // raises the flag on its own edge and no overshoot can occur.
    always_comb begin
        rd_acc  = bus.RD_EN_i & ~empty_q;
        wq1_d   = bus.WPTR_GRAY_i;
        wq2_d   = wq1_q;
        rbin_d  = rbin_q + {{(PW-1){1'b0}}, rd_acc};
        rgray_d = rbin_d ^ (rbin_d >> 1);
        empty_d = (rgray_d == wq2_q);
        ack_d   = rd_acc;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            wq1_q   <= '0;
            wq2_q   <= '0;
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            wq1_q   <= wq1_d;
            wq2_q   <= wq2_d;
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.RPTR_GRAY_o = rgray_q;
    assign bus.RADDR_o     = rbin_q[ADDR_W-1:0];
    assign bus.EMPTY_o     = empty_q;
    assign bus.RD_ACK_o    = ack_q;

`ifdef RPTR_LEVEL_EN
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] level_d;
    logic [PW-1:0] level_q;
    logic          ae_d;
    logic          ae_q;

    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(wq2_q >> i);
        end
        level_d = wbin - rbin_d;
        ae_d    = (level_d <= AE_LVL);
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            level_q <= '0;
            ae_q    <= 1'b1;
        end else begin
            level_q <= level_d;
            ae_q    <= ae_d;
        end
    end

    assign bus.LEVEL_o        = level_q;
    assign bus.ALMOST_EMPTY_o = ae_q;
`else
    logic unused_ae_thresh;
    assign unused_ae_thresh   = ^AE_THRESH;
    assign bus.LEVEL_o        = '0;
    assign bus.ALMOST_EMPTY_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Randomized bench for fifo_rd_ptr_ctrl against a count-based FIFO model.
module tb_fifo_rd_ptr_ctrl;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_ptr_ctrl_if #(.ADDR_W(AW)) bus ();

    fifo_rd_ptr_ctrl #(.ADDR_W(AW), .AE_THRESH(2)) dut (
        .CLK_i(clk),
        .RST_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: plain item counts; pointers are the counts mod 32.
    int m_w = 0;
    int m_r = 0;
    int w_seen1 = 0;
    int w_seen2 = 0;
    int m_lvl = 0;
    bit m_empty = 1'b1;
    bit m_ack = 1'b0;
    bit m_ae = 1'b1;
    bit m_rst = 1'b1;
    bit check_en = 1'b0;
    bit wrap_seen = 1'b0;
    logic [4:0] prev_gray = '0;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_w(input int v);
        m_w = v;
        bus.WPTR_GRAY_i = gray(v);
    endtask

    always @(posedge clk) begin
        m_rst = rst;
        if (rst) begin
            m_r = 0;
            w_seen1 = 0;
            w_seen2 = 0;
            m_lvl = 0;
            m_empty = 1'b1;
            m_ack = 1'b0;
            m_ae = 1'b1;
        end else begin
            m_ack = bus.RD_EN_i && !m_empty;
            m_r = m_r + int'(m_ack);
            m_lvl = (w_seen2 - m_r) & 31;
            m_empty = (m_lvl == 0);
            m_ae = (m_lvl <= 2);
            w_seen2 = w_seen1;
            w_seen1 = m_w;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("empty", int'(bus.EMPTY_o), int'(m_empty));
            chk("rd_ack", int'(bus.RD_ACK_o), int'(m_ack));
            chk("raddr", int'(bus.RADDR_o), m_r % 16);
            chk("rptr_gray", int'(bus.RPTR_GRAY_o), int'(gray(m_r)));
`ifdef RPTR_LEVEL_EN
            chk("level", int'(bus.LEVEL_o), m_lvl);
            chk("almost_empty", int'(bus.ALMOST_EMPTY_o), int'(m_ae));
`else
            chk("level_tied", int'(bus.LEVEL_o), 0);
            chk("ae_tied", int'(bus.ALMOST_EMPTY_o), 0);
`endif
            if (!m_rst) begin
                chk("gray_step", int'($countones(bus.RPTR_GRAY_o ^ prev_gray) <= 1), 1);
                if (prev_gray == 5'b10000 && bus.RPTR_GRAY_o == 5'b00000)
                    wrap_seen = 1'b1;
            end
            prev_gray = bus.RPTR_GRAY_o;
        end
    end

    initial begin
        int acks;
        int cyc;
        rst = 1'b1;
        bus.RD_EN_i = 1'b0;
        set_w(0);
        @(posedge clk);
        #1 check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", int'(bus.EMPTY_o), 1);
        chk("rst_rptr", int'(bus.RPTR_GRAY_o), 0);
        chk("rst_raddr", int'(bus.RADDR_o), 0);
`ifdef RPTR_LEVEL_EN
        chk("rst_ae", int'(bus.ALMOST_EMPTY_o), 1);
`endif

        // Reads while empty are ignored.
        bus.RD_EN_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ack", int'(bus.RD_ACK_o), 0);
        end
        chk("idle_raddr", int'(bus.RADDR_o), 0);
        chk("idle_rptr", int'(bus.RPTR_GRAY_o), 0);

        // Write pointer 0 -> 2: empty falls on the third edge.
        bus.RD_EN_i = 1'b0;
        set_w(2);
        @(negedge clk);
        chk("lat_e1", int'(bus.EMPTY_o), 1);
        @(negedge clk);
        chk("lat_e2", int'(bus.EMPTY_o), 1);
        @(negedge clk);
        chk("lat_e3", int'(bus.EMPTY_o), 0);
`ifdef RPTR_LEVEL_EN
        chk("lat_level", int'(bus.LEVEL_o), 2);
`endif

        // Drain two entries with four read cycles.
        bus.RD_EN_i = 1'b1;
        acks = 0;
        @(negedge clk);
        chk("drain_raddr1", int'(bus.RADDR_o), 1);
        chk("drain_empty1", int'(bus.EMPTY_o), 0);
        acks += int'(bus.RD_ACK_o);
        @(negedge clk);
        chk("drain_raddr2", int'(bus.RADDR_o), 2);
        chk("drain_empty2", int'(bus.EMPTY_o), 1);
        acks += int'(bus.RD_ACK_o);
        repeat (2) begin
            @(negedge clk);
            acks += int'(bus.RD_ACK_o);
        end
        bus.RD_EN_i = 1'b0;
        chk("drain_acks", acks, 2);
        chk("drain_raddr", int'(bus.RADDR_o), 2);
        chk("drain_rptr", int'(bus.RPTR_GRAY_o), 3);

        // Fill to level 4 then read twice.
        for (int v = 3; v <= 6; v++) begin
            set_w(v);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("ae_pre_empty", int'(bus.EMPTY_o), 0);
`ifdef RPTR_LEVEL_EN
        chk("ae_lvl4", int'(bus.LEVEL_o), 4);
        chk("ae_at4", int'(bus.ALMOST_EMPTY_o), 0);
`endif
        bus.RD_EN_i = 1'b1;
        @(negedge clk);
`ifdef RPTR_LEVEL_EN
        chk("ae_lvl3", int'(bus.LEVEL_o), 3);
        chk("ae_at3", int'(bus.ALMOST_EMPTY_o), 0);
`endif
        @(negedge clk);
        bus.RD_EN_i = 1'b0;
`ifdef RPTR_LEVEL_EN
        chk("ae_lvl2", int'(bus.LEVEL_o), 2);
        chk("ae_at2", int'(bus.ALMOST_EMPTY_o), 1);
`endif
        chk("ae_raddr", int'(bus.RADDR_o), 4);

        // Stream 40 reads across the pointer wrap.
        acks = 0;
        cyc = 0;
        wrap_seen = 1'b0;
        while (acks < 40 && cyc < 2000) begin
            if (m_w - m_r < 16 && $urandom_range(3) != 0)
                set_w(m_w + 1);
            bus.RD_EN_i = ($urandom_range(3) != 0);
            @(negedge clk);
            cyc++;
            acks += int'(bus.RD_ACK_o);
        end
        bus.RD_EN_i = 1'b0;
        @(negedge clk);
        acks += int'(bus.RD_ACK_o);
        chk("wrap_budget", int'(cyc < 2000), 1);
        chk("wrap_reads", acks, 40);
        chk("wrap_seen", int'(wrap_seen), 1);
        chk("wrap_raddr", int'(bus.RADDR_o), 12);
        chk("wrap_rptr", int'(bus.RPTR_GRAY_o), 10);

        // Free-running random traffic.
        repeat (400) begin
            if (m_w - m_r < 16 && $urandom_range(1) != 0)
                set_w(m_w + 1);
            bus.RD_EN_i = $urandom_range(1);
            @(negedge clk);
        end

        // Reset with both sides cleared, refill, read to rbin=7.
        bus.RD_EN_i = 1'b0;
        rst = 1'b1;
        set_w(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            set_w(v);
            @(negedge clk);
        end
        bus.RD_EN_i = 1'b1;
        cyc = 0;
        while (bus.RADDR_o != 4'd7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reach7", int'(bus.RADDR_o), 7);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_empty", int'(bus.EMPTY_o), 1);
        chk("mid_rptr", int'(bus.RPTR_GRAY_o), 0);
        chk("mid_raddr", int'(bus.RADDR_o), 0);
        chk("mid_ack", int'(bus.RD_ACK_o), 0);
        chk("mid_wq2", int'(dut.wq2_q), 0);
        chk("mid_level", int'(bus.LEVEL_o), 0);
`ifdef RPTR_LEVEL_EN
        chk("mid_ae", int'(bus.ALMOST_EMPTY_o), 1);
`endif
        rst = 1'b0;
        repeat (20) @(negedge clk);
        bus.RD_EN_i = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ptr_ctrl.md
# fifo_rd_ptr_ctrl

Read-side pointer and empty-flag controller for the asynchronous FIFO, running entirely in the read clock domain. It takes the write-domain Gray pointer and passes it through a two-flop synchronizer. It converts the synchronized value to binary by prefix-XOR, the same conversion as the FIFO's Gray-to-binary stage. It maintains the binary and Gray read pointers and produces a registered EMPTY flag, the RAM read address, and an optional fill level.

## Interface
- ADDR_W, default 4: RAM address width; pointers are ADDR_W+1 bits (5 by default).
- AE_THRESH, default 2: almost-empty threshold in entries (used only with the level feature).

Ports:
- CLK_i  input  1  read-domain clock
- RST_i  input  1  reset; synchronous, active-high, acts on the CLK_i rising edge
- RD_EN_i  input  1  read request from consumer
- WPTR_GRAY_i  input  ADDR_W+1  write pointer, Gray coded, asynchronous to CLK_i
- RPTR_GRAY_o  output  ADDR_W+1  registered read pointer, Gray coded, sent to the write domain
- RADDR_o  output  ADDR_W  RAM read address = rbin[ADDR_W-1:0]
- EMPTY_o  output  1  registered empty flag
- RD_ACK_o  output  1  registered; high one cycle after an accepted read
- LEVEL_o  output  ADDR_W+1  registered fill level (RPTR_LEVEL_EN only)
- ALMOST_EMPTY_o  output  1  registered, LEVEL_o <= AE_THRESH (RPTR_LEVEL_EN only)

## Operation
- Synchronizer: wq1 <= WPTR_GRAY_i; wq2 <= wq1. There is no logic between WPTR_GRAY_i and wq1.
- Accept: rd_acc = RD_EN_i & ~EMPTY_o. A read while EMPTY_o=1 is ignored: pointers do not change and RD_ACK_o stays 0.
- Next pointer: rbin_nxt = rbin + rd_acc, modulo 2^(ADDR_W+1).
- Gray next: rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1).
- Registered updates: rbin <= rbin_nxt; rgray <= rgray_nxt; EMPTY_o <= (rgray_nxt == wq2).
- RPTR_GRAY_o is driven directly from the rgray register, with no combinational logic after it. It changes in at most one bit per cycle.
- Wrap-around: at the default width, rbin goes 31 -> 0 and rgray goes 10000 -> 00000. This needs no special handling.
- Binary conversion of wq2: wbin[i] = XOR of wq2[ADDR_W:i].
- Reset values: rbin=0, rgray=0, wq1=0, wq2=0, RADDR_o=0, RPTR_GRAY_o=0, EMPTY_o=1, RD_ACK_o=0, LEVEL_o=0, ALMOST_EMPTY_o=1.
- Reset mid-operation: RST_i has priority over RD_EN_i. All state returns to the reset values on the next edge, whatever the write pointer is.

## Timing
- Write-pointer propagation:
  - WPTR_GRAY_i changes before edge N.
  - wq1 updates at edge N, wq2 at edge N+1.
  - EMPTY_o falls at edge N+2, a 3-edge latency.
- Empty assertion:
  - A read that consumes the last entry, accepted at edge N, sets EMPTY_o=1 at edge N itself, because the comparison uses rgray_nxt.
  - There is no overshoot: the following read is refused.
- Read acknowledge: for an accepted read at edge N, RAM data at RADDR_o (old value) is valid before edge N, and RD_ACK_o=1 after edge N.
- Simultaneous write arrival and a final read in the same cycle: the comparison uses the current wq2. The new entry appears two edges later; EMPTY_o pulses high in between. This is pessimistic and allowed.
- Back-to-back reads are allowed every cycle while EMPTY_o=0.

## Configuration
- Macro: RPTR_LEVEL_EN.
- Defined:
  - LEVEL_o <= (wbin - rbin_nxt) mod 2^(ADDR_W+1), range 0..2^ADDR_W.
  - ALMOST_EMPTY_o <= (that level <= AE_THRESH).
  - Both are registered, with the same edge as EMPTY_o.
- Undefined:
  - LEVEL_o and ALMOST_EMPTY_o are tied to 0.
  - No wbin conversion logic is built.
  - All other behaviour is identical.

## Test plan
- Reset, WPTR_GRAY_i=0: EMPTY_o=1, RPTR_GRAY_o=0, RADDR_o=0. RD_EN_i=1 held for 5 cycles leaves the pointers at 0 and RD_ACK_o at 0.
- Propagation latency: WPTR_GRAY_i 00000 -> 00011 (binary 2) before edge N gives EMPTY_o=0 after edge N+2. With RPTR_LEVEL_EN, LEVEL_o=2 at the same edge.
- Drain: with 2 entries, hold RD_EN_i for 4 cycles. Result: RADDR_o 0 -> 1 -> 2, exactly 2 RD_ACK_o pulses, EMPTY_o=1 on the edge of the 2nd read, RPTR_GRAY_o=00011.
- Wrap: stream 40 writes/reads with the write pointer kept ahead. rbin passes 31 -> 0 and RPTR_GRAY_o goes 10000 -> 00000. Check that every RPTR_GRAY_o change is a single bit and that the total read count is 40.
- Mid-operation reset: at rbin=7, assert RST_i together with RD_EN_i=1. After 1 edge all outputs are at their reset values and wq2=0.
- Almost-empty, RPTR_LEVEL_EN with AE_THRESH=2: at level 4, read twice, and ALMOST_EMPTY_o rises on the 2nd accepted read (level 2).
